// File: rtl/muxe_pipe_pkg.sv
// Shared types and helpers for the registered select-by-index mux.
// Lock FSM states and the select-width helper used by every muxe_pipe file.
package muxe_pipe_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } lock_state_e;

   // Width of a binary index over n channels; never narrower than one bit.
   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/muxe_pipe_lock.sv
// Packet lock: holds the channel index from a packet's first accepted beat to its last.
// Combinational eff_sel from registered state; no backpressure of its own (advances on accept only).
module muxe_pipe_lock
   import muxe_pipe_pkg::*;
#(
   parameter  int N        = 4,
   parameter  int PKT_MODE = 1,
   localparam int SEL_W    = sel_w(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SEL_W-1:0] sel_i,
   input  logic             accept_i,
   input  logic             last_i,
   output logic [SEL_W-1:0] eff_sel_o,
   output logic             locked_o
);

   lock_state_e      state_q;
   logic [SEL_W-1:0] lock_sel_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         lock_sel_q <= '0;
      end else if ((PKT_MODE != 0) && accept_i) begin
         case (state_q)
            // A single-beat packet (last on the first beat) never locks.
            IDLE: begin
               if (!last_i) begin
                  state_q    <= LOCKED;
                  lock_sel_q <= eff_sel_o;
               end
            end
            LOCKED: begin
               if (last_i) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign locked_o  = (state_q == LOCKED);
   assign eff_sel_o = locked_o ? lock_sel_q : sel_i;

endmodule

// File: rtl/muxe_pipe.sv
// N:1 valid/ready mux selected by binary index, one-entry registered output stage, optional packet lock.
// Latency 1 cycle; full throughput; ready only to the selected channel and only when the stage can take a beat.
module muxe_pipe
   import muxe_pipe_pkg::*;
#(
   parameter  int N        = 4,
   parameter  int W        = 32,
   parameter  int PKT_MODE = 1,
   localparam int SEL_W    = sel_w(N)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N-1:0]          i_in_vld,
   input  logic [N-1:0][W-1:0]   i_in_data,
   input  logic [N-1:0]          i_in_last,
   output logic [N-1:0]          o_in_rdy,
   input  logic [SEL_W-1:0]      i_sel,
   output logic                  o_out_vld,
   output logic [W-1:0]          o_out_data,
   output logic                  o_out_last,
   output logic [SEL_W-1:0]      o_out_sel,
   input  logic                  i_out_rdy,
   output logic                  o_locked,
   output logic                  o_sel_err
);

   logic [SEL_W-1:0] eff_sel;
   logic             locked;
   logic             sel_ok;
   logic             stage_free;
   logic             accept;
   logic             last_sel;
   logic [N-1:0]     sel_oh;
   logic [W-1:0]     data_sel;

   logic             out_vld_q;
   logic [W-1:0]     out_data_q;
   logic             out_last_q;
   logic [SEL_W-1:0] out_sel_q;
   logic             sel_err_q;

   muxe_pipe_lock #(
      .N        (N),
      .PKT_MODE (PKT_MODE)
   ) u_lock (
      .clk       (clk),
      .rst       (rst),
      .sel_i     (i_sel),
      .accept_i  (accept),
      .last_i    (last_sel),
      .eff_sel_o (eff_sel),
      .locked_o  (locked)
   );

   // Out-of-range indices (only possible when N is not a power of two) decode to no channel.
   assign sel_ok     = int'(eff_sel) < N;
   assign stage_free = !out_vld_q || i_out_rdy;

   always_comb begin
      sel_oh = '0;
      for (int k = 0; k < N; k++) begin
         sel_oh[k] = sel_ok && (int'(eff_sel) == k);
      end
   end

   always_comb begin
      data_sel = '0;
      last_sel = 1'b0;
      for (int k = 0; k < N; k++) begin
         data_sel = data_sel | ({W{sel_oh[k]}} & i_in_data[k]);
         last_sel = last_sel | (sel_oh[k] & i_in_last[k]);
      end
   end

   assign o_in_rdy = (stage_free && !rst) ? sel_oh : '0;
   assign accept   = |(i_in_vld & o_in_rdy);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld_q  <= 1'b0;
         out_data_q <= '0;
         out_last_q <= 1'b0;
         out_sel_q  <= '0;
         sel_err_q  <= 1'b0;
      end else begin
         if (accept) begin
            out_vld_q  <= 1'b1;
            out_data_q <= data_sel;
            out_last_q <= last_sel;
            out_sel_q  <= eff_sel;
         end else if (i_out_rdy) begin
            out_vld_q  <= 1'b0;
         end
         sel_err_q <= !locked && (int'(i_sel) >= N);
      end
   end

   assign o_out_vld  = out_vld_q;
   assign o_out_data = out_data_q;
   assign o_out_last = out_last_q;
   assign o_out_sel  = out_sel_q;
   assign o_locked   = locked;
   assign o_sel_err  = sel_err_q;

endmodule

// File: tb/tb_muxe_pipe.sv
// Three DUTs (N=4 packet mode, N=4 beat mode, N=3 packet mode) checked against a per-cycle
// transaction model plus hand-computed pinned values.
module tb_muxe_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   localparam int NN [3] = '{4, 4, 3};
   localparam int PK [3] = '{1, 0, 1};

   logic             rst_s  [3];
   logic [3:0]       vld_s  [3];
   logic [3:0][7:0]  dat_s  [3];
   logic [3:0]       lst_s  [3];
   logic [1:0]       sel_s  [3];
   logic             ordy_s [3];

   logic [3:0]       irdy_o [3];
   logic [2:0]       irdy2;
   logic             ov  [3];
   logic [7:0]       od  [3];
   logic             ol  [3];
   logic [1:0]       os  [3];
   logic             olk [3];
   logic             oerr[3];

   int  n_cmp = 0;
   int  n_bad = 0;
   bit  done  = 1'b0;

   muxe_pipe #(.N(4), .W(8), .PKT_MODE(1)) u0 (
      .clk(clk), .rst(rst_s[0]), .i_in_vld(vld_s[0]), .i_in_data(dat_s[0]),
      .i_in_last(lst_s[0]), .o_in_rdy(irdy_o[0]), .i_sel(sel_s[0]),
      .o_out_vld(ov[0]), .o_out_data(od[0]), .o_out_last(ol[0]), .o_out_sel(os[0]),
      .i_out_rdy(ordy_s[0]), .o_locked(olk[0]), .o_sel_err(oerr[0]));

   muxe_pipe #(.N(4), .W(8), .PKT_MODE(0)) u1 (
      .clk(clk), .rst(rst_s[1]), .i_in_vld(vld_s[1]), .i_in_data(dat_s[1]),
      .i_in_last(lst_s[1]), .o_in_rdy(irdy_o[1]), .i_sel(sel_s[1]),
      .o_out_vld(ov[1]), .o_out_data(od[1]), .o_out_last(ol[1]), .o_out_sel(os[1]),
      .i_out_rdy(ordy_s[1]), .o_locked(olk[1]), .o_sel_err(oerr[1]));

   muxe_pipe #(.N(3), .W(8), .PKT_MODE(1)) u2 (
      .clk(clk), .rst(rst_s[2]), .i_in_vld(vld_s[2][2:0]), .i_in_data(dat_s[2][2:0]),
      .i_in_last(lst_s[2][2:0]), .o_in_rdy(irdy2), .i_sel(sel_s[2]),
      .o_out_vld(ov[2]), .o_out_data(od[2]), .o_out_last(ol[2]), .o_out_sel(os[2]),
      .i_out_rdy(ordy_s[2]), .o_locked(olk[2]), .o_sel_err(oerr[2]));

   assign irdy_o[2] = {1'b0, irdy2};

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: what each DUT's output stage must hold, derived from the beat rules.
   bit        mv   [3];
   logic [7:0] md  [3];
   bit        mlst [3];
   int        ms   [3];
   bit        mlk  [3];
   int        mls  [3];
   bit        merr [3];

   initial begin : cmp
      for (int d = 0; d < 3; d++) begin
         mv[d] = 0; md[d] = '0; mlst[d] = 0; ms[d] = 0; mlk[d] = 0; mls[d] = 0; merr[d] = 0;
      end
      @(posedge clk);
      while (!done) begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            int         es;
            logic [3:0] er;
            bit         acc;
            chk("out_vld", d, 32'(ov[d]), 32'(mv[d]));
            if (mv[d]) begin
               chk("out_data", d, 32'(od[d]), 32'(md[d]));
               chk("out_last", d, 32'(ol[d]), 32'(mlst[d]));
               chk("out_sel",  d, 32'(os[d]), 32'(ms[d]));
            end
            chk("locked",  d, 32'(olk[d]),  32'(mlk[d]));
            chk("sel_err", d, 32'(oerr[d]), 32'(merr[d]));

            es = mlk[d] ? mls[d] : int'(sel_s[d]);
            er = 4'b0000;
            if (!rst_s[d] && (!mv[d] || ordy_s[d]) && es < NN[d]) er = 4'b0001 << es;
            chk("in_rdy", d, 32'(irdy_o[d]), 32'(er));
            acc = (er != 4'b0000) && vld_s[d][es];

            if (rst_s[d]) begin
               mv[d] = 0; md[d] = '0; mlst[d] = 0; ms[d] = 0; mlk[d] = 0; mls[d] = 0; merr[d] = 0;
            end else begin
               merr[d] = !mlk[d] && (int'(sel_s[d]) >= NN[d]);
               if (acc) begin
                  mv[d] = 1; md[d] = dat_s[d][es]; mlst[d] = lst_s[d][es]; ms[d] = es;
                  if (PK[d] != 0) begin
                     if (!mlk[d] && !lst_s[d][es]) begin mlk[d] = 1; mls[d] = es; end
                     else if (mlk[d] && lst_s[d][es]) mlk[d] = 0;
                  end
               end else if (ordy_s[d]) begin
                  mv[d] = 0;
               end
            end
         end
      end
   end

   initial begin : stim
      for (int d = 0; d < 3; d++) begin
         rst_s[d] = 1; vld_s[d] = '0; dat_s[d] = '0; lst_s[d] = '0; sel_s[d] = '0; ordy_s[d] = 1;
      end
      step(); step();
      for (int d = 0; d < 3; d++) rst_s[d] = 0;

      // Single-beat packet on ch2.
      sel_s[0] = 2; vld_s[0][2] = 1; dat_s[0][2] = 8'hA5; lst_s[0][2] = 1;
      @(negedge clk);
      chk("reset_vld", 0, 32'(ov[0]), 0);
      chk("first_rdy", 0, 32'(irdy_o[0]), 32'b0100);
      step();

      // Stage full under backpressure: no ready, contents frozen.
      vld_s[0] = '0; ordy_s[0] = 0;
      @(negedge clk);
      chk("first_vld",  0, 32'(ov[0]), 1);
      chk("first_data", 0, 32'(od[0]), 32'hA5);
      chk("first_sel",  0, 32'(os[0]), 2);
      chk("first_last", 0, 32'(ol[0]), 1);
      chk("first_lock", 0, 32'(olk[0]), 0);
      step();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_rdy",  0, 32'(irdy_o[0]), 0);
         chk("bp_data", 0, 32'(od[0]), 32'hA5);
         step();
      end

      // Drain and load in the same cycle.
      sel_s[0] = 1; vld_s[0][1] = 1; dat_s[0][1] = 8'h3C; lst_s[0][1] = 1; ordy_s[0] = 1;
      @(negedge clk);
      chk("swap_rdy", 0, 32'(irdy_o[0]), 32'b0010);
      step();
      vld_s[0] = '0;
      @(negedge clk);
      chk("swap_vld",  0, 32'(ov[0]), 1);
      chk("swap_data", 0, 32'(od[0]), 32'h3C);
      step();

      // Three-beat packet on ch0, select moves to ch3 after beat 1; packet mode and beat mode side by side.
      for (int d = 0; d < 2; d++) begin
         sel_s[d] = 0; vld_s[d] = 4'b1001; dat_s[d][0] = 8'h10; lst_s[d] = 4'b1000; dat_s[d][3] = 8'h30;
      end
      @(negedge clk);
      chk("pkt_idle_vld", 0, 32'(ov[0]), 0);
      step();
      for (int d = 0; d < 2; d++) begin sel_s[d] = 3; dat_s[d][0] = 8'h11; end
      @(negedge clk);
      chk("pkt_lock",  0, 32'(olk[0]), 1);
      chk("pkt_rdy",   0, 32'(irdy_o[0]), 32'b0001);
      chk("pkt_b1",    0, 32'(od[0]), 32'h10);
      chk("beat_rdy",  1, 32'(irdy_o[1]), 32'b1000);
      chk("beat_lock", 1, 32'(olk[1]), 0);
      step();
      dat_s[0][0] = 8'h12; lst_s[0][0] = 1; vld_s[1] = '0;
      @(negedge clk);
      chk("pkt_b2",   0, 32'(od[0]), 32'h11);
      chk("beat_sel", 1, 32'(os[1]), 3);
      chk("beat_dat", 1, 32'(od[1]), 32'h30);
      step();
      vld_s[0][0] = 0;
      @(negedge clk);
      chk("pkt_b3",     0, 32'(od[0]), 32'h12);
      chk("pkt_unlock", 0, 32'(olk[0]), 0);
      chk("pkt_ch3rdy", 0, 32'(irdy_o[0]), 32'b1000);
      step();
      vld_s[0] = '0;
      @(negedge clk);
      chk("pkt_ch3dat", 0, 32'(od[0]), 32'h30);
      chk("pkt_ch3sel", 0, 32'(os[0]), 3);
      step();

      // N=3 with out-of-range select.
      vld_s[2] = 4'b0111; lst_s[2] = 4'b0111; dat_s[2] = 32'h00_33_22_11; sel_s[2] = 0;
      step();
      sel_s[2] = 3;
      @(negedge clk);
      chk("oor_full", 2, 32'(ov[2]), 1);
      chk("oor_rdy",  2, 32'(irdy_o[2]), 0);
      step();
      vld_s[2] = '0;
      @(negedge clk);
      chk("oor_err",   2, 32'(oerr[2]), 1);
      chk("oor_drain", 2, 32'(ov[2]), 0);
      step();

      // Reset mid-packet with a held beat.
      sel_s[0] = 0; vld_s[0][0] = 1; dat_s[0][0] = 8'h77; lst_s[0][0] = 0; ordy_s[0] = 0;
      step();
      rst_s[0] = 1; vld_s[0] = '0;
      @(negedge clk);
      chk("mid_lock", 0, 32'(olk[0]), 1);
      chk("mid_vld",  0, 32'(ov[0]), 1);
      chk("rst_rdy",  0, 32'(irdy_o[0]), 0);
      step();
      rst_s[0] = 0; sel_s[0] = 1; vld_s[0][1] = 1; dat_s[0][1] = 8'h42; lst_s[0][1] = 1; ordy_s[0] = 1;
      @(negedge clk);
      chk("rst_vld",  0, 32'(ov[0]), 0);
      chk("rst_data", 0, 32'(od[0]), 0);
      chk("rst_lock", 0, 32'(olk[0]), 0);
      chk("rst_sel",  0, 32'(os[0]), 0);
      chk("post_rdy", 0, 32'(irdy_o[0]), 32'b0010);
      step();
      vld_s[0] = '0;
      @(negedge clk);
      chk("post_data", 0, 32'(od[0]), 32'h42);
      chk("post_sel",  0, 32'(os[0]), 1);
      step();

      done = 1'b1;
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/muxe_pipe.md
Name: muxe_pipe

Overview:
- Parametrised, registered successor to the encoded-select N:1 mux.
- Selects one of N valid/ready input channels by binary index, and buffers the chosen beat in a one-entry output stage with full-throughput valid/ready flow.
- Optional packet mode holds the selection across a multi-beat packet, from first beat to the beat carrying last.
- Sits between per-source queues and a shared downstream consumer.

Parameters:
- N, 4, number of input channels; N >= 2; need not be a power of two.
- W, 32, data width per channel in bits.
- PKT_MODE, 1, 1 = hold selection from first beat until the last beat is accepted; 0 = select per beat.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- i_in_vld  in  N  per-channel valid.
- i_in_data  in  N x W  per-channel data, packed [N-1:0][W-1:0].
- i_in_last  in  N  per-channel end-of-packet.
- o_in_rdy  out  N  per-channel ready; one-hot or zero.
- i_sel  in  $clog2(N)  binary channel select.
- o_out_vld  out  1  output beat valid.
- o_out_data  out  W  output data.
- o_out_last  out  1  output end-of-packet.
- o_out_sel  out  $clog2(N)  source channel of the current output beat.
- i_out_rdy  in  1  downstream ready.
- o_locked  out  1  selection held mid-packet.
- o_sel_err  out  1  registered flag: out-of-range select presented last cycle.

Behaviour:
- Reset values: o_out_vld=0, o_out_data=0, o_out_last=0, o_out_sel=0, o_locked=0, o_sel_err=0, internal lock_sel=0.
- o_in_rdy is forced to 0 while rst=1.
- stage_free = !o_out_vld || i_out_rdy.
- eff_sel = o_locked ? lock_sel : i_sel.
- o_in_rdy[k] = stage_free && (k == eff_sel) && (eff_sel < N). This is combinational; no ready-to-valid dependency on the input side.
- accept = i_in_vld[eff_sel] && o_in_rdy[eff_sel].
- On accept: o_out_data, o_out_last and o_out_sel load from channel eff_sel on the next edge, and o_out_vld becomes 1.
- No accept and i_out_rdy=1: o_out_vld becomes 0 and the data registers hold.
- No accept and i_out_rdy=0: all output registers hold.
- Latency: exactly 1 cycle from input accept to o_out_vld.
- Throughput: 1 beat/cycle when i_out_rdy is held high. A drain and an accept in the same cycle keep o_out_vld=1 with the new beat.
- Output stability: while o_out_vld=1 and i_out_rdy=0, all o_out_* outputs are stable.
- Lock FSM, PKT_MODE=1, two states:
  - IDLE -> LOCKED on an accept with i_in_last[eff_sel]=0; lock_sel <= eff_sel.
  - LOCKED -> IDLE on an accept with last=1.
  - An accept with last=1 in IDLE stays IDLE (single-beat packet).
  - o_locked=1 exactly in LOCKED.
  - i_sel is ignored while LOCKED.
- PKT_MODE=0: FSM stays IDLE, o_locked=0, and i_in_last is passed through as data.
- o_sel_err <= !o_locked && (i_sel >= N), evaluated every cycle. Out-of-range select gives no ready and no accept. The flag is constant 0 when N is a power of two.
- Non-selected channels always see ready=0. Their valid/data are don't-care and must not affect outputs.
- Reset mid-packet returns to IDLE, clears the output stage and drops any held beat. Upstream is responsible for packet recovery.

Decomposition:
- Package muxe_pipe_pkg holds:
  - the lock state enum (IDLE, LOCKED);
  - a SEL_W function/localparam helper equal to $clog2(N).
- Datapath reuses the common dec (select to one-hot) and mux (one-hot select) primitives.
- One natural new sub-module: muxe_pipe_lock, the lock FSM plus lock_sel register, outputting eff_sel and o_locked.

Test Plan:
- Reset, then N=4, W=8, PKT_MODE=1, i_sel=2, ch2 vld with data 0xA5, last=1, i_out_rdy=1 -> o_in_rdy=4'b0100. Next cycle o_out_vld=1, o_out_data=0xA5, o_out_sel=2, o_out_last=1, o_locked=0.
- Backpressure: i_out_rdy=0 with the stage full -> o_in_rdy=0 and outputs stable for 5 cycles. Raise i_out_rdy while ch1 is valid with i_sel=1 -> drain and load in the same cycle, o_out_vld stays 1 with the ch1 data.
- Packet lock: ch0 sends 3 beats 0x10, 0x11, 0x12 (last on the third). i_sel switches to 3 after the first beat -> o_locked=1 for beats 2-3, ch3 never ready, all three beats exit in order from ch0. o_locked=0 after 0x12 is accepted; the next ch3 beat then proceeds.
- PKT_MODE=0, same stimulus as the packet-lock case -> ch3 is selected on the cycle after the switch, and o_locked stays 0 throughout.
- N=3, i_sel=3 with all channels valid -> o_in_rdy=0, o_sel_err=1 on the following cycle, o_out_vld drains to 0.
- rst asserted mid-packet (o_locked=1, o_out_vld=1) -> next cycle all outputs are at reset values. After release, i_sel=1 is honoured immediately.
